acc_src_reg: RTL and testbench
==============================

Name: acc_src_reg

Overview:
Parametrised, registered successor to the accumulator-A source multiplexer. It selects one of NUM_SRC equal-width sources into an accumulator register, with load/clear control, a valid/ready output handshake and registered status flags. Out-of-range selects are trapped and reported instead of being silently held. It sits between the ALU, data memory, immediate extender and any added sources, and the accumulator consumers in the datapath.

Parameters:
DATA_WIDTH, 11, width of every source and of the accumulator.
NUM_SRC, 3, number of source channels; legal range 2..16.
SEL_WIDTH, $clog2(NUM_SRC), width of the select bus; minimum 1.
RESET_VALUE, 0, accumulator value after reset and after clear.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
src_in  in  NUM_SRC*DATA_WIDTH  packed sources; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
sel  in  SEL_WIDTH  channel index.
load  in  1  request to capture src_in[sel] into the accumulator.
clear  in  1  synchronous clear of the accumulator to RESET_VALUE.
load_ready  out  1  load is accepted this cycle.
acc_out  out  DATA_WIDTH  accumulator register.
out_valid  out  1  acc_out holds a fresh, unconsumed value.
out_ready  in  1  consumer takes acc_out this cycle.
acc_zero  out  1  registered: acc_out == 0.
acc_neg  out  1  registered: acc_out MSB.
sel_err  out  1  sticky illegal-select flag.
err_clr  in  1  clears sel_err.

Behaviour:
- Reset (async, immediate): acc_out=RESET_VALUE; out_valid=0; sel_err=0; acc_zero=(RESET_VALUE==0); acc_neg=RESET_VALUE[MSB]. No register is written while rst is high.
- load_ready is combinational: load_ready = !out_valid || out_ready.
- Accepted load: load && load_ready && !clear && sel<NUM_SRC.
- On an accepted load, at the next edge: acc_out=src_in[sel], out_valid=1, and the flags reflect the new value. Latency is 1 cycle; back-to-back loads are allowed when out_ready=1.
- Illegal select: load && load_ready && !clear && sel>=NUM_SRC.
  - acc_out and the flags hold.
  - sel_err=1 at the next edge.
  - out_valid follows the consume rule only; no fresh value is produced.
  - When NUM_SRC is a power of two this path is unreachable.
- load while !load_ready (stall): ignored. acc_out, out_valid, flags and sel_err all hold. Upstream must hold the request.
- Consume: out_valid && out_ready with no accepted load → out_valid=0 at the next edge. acc_out keeps its value.
- Simultaneous consume and accepted load: out_valid stays 1 and acc_out takes the new value.
- clear: highest priority, ignores load_ready and sel. At the next edge: acc_out=RESET_VALUE, out_valid=0, flags recomputed. clear && load: the load is dropped and sel_err is not set.
- sel_err: set by an illegal select; cleared by err_clr. Set wins over err_clr in the same cycle. It is not affected by clear.
- Flags are always derived from the registered acc_out, never from src_in.
- No latches: every register has an explicit hold path. Outputs are glitch-free except load_ready.
- Reset asserted mid-operation: all state returns to reset values immediately. Pending handshakes are lost.

Test Plan:
- Reset/basic load, defaults, rst pulse during an active load → all reset values immediately. Then sel=2, src2=11'h3A5, load=1, out_ready=1 → next cycle acc_out=11'h3A5, out_valid=1, acc_neg=0, acc_zero=0.
- Stall, defaults: load ch0=11'h400 with out_ready=0 → out_valid=1, acc_neg=1. Then load ch1=11'h001 while out_ready=0 → load_ready=0, acc_out stays 11'h400. Raise out_ready → ch1 accepted, acc_out=11'h001 next cycle.
- Illegal select, NUM_SRC=3: sel=3, load=1 → acc_out unchanged, sel_err=1 and stays 1. err_clr together with another illegal load → sel_err stays 1. err_clr alone → sel_err=0.
- Clear priority: acc_out=11'h7FF valid; assert clear+load with sel=3 → acc_out=0, acc_zero=1, out_valid=0, sel_err unchanged.
- Consume-only: out_valid=1, out_ready=1, load=0 → out_valid=0 next cycle, acc_out unchanged.
- Parametrisation, NUM_SRC=4, DATA_WIDTH=16: walk sel 0..3 with distinct patterns 16'h0000/16'h8001/16'h1234/16'hFFFF → correct capture and flags each cycle; sel_err never set.

Source files
------------

// File: rtl/acc_src_reg.sv
// acc_src_reg
//   Registered accumulator-A source selector. One of NUM_SRC equal-width
//   sources is captured into the accumulator. The block provides
//   load/clear control, a valid/ready output handshake, registered
//   zero/negative flags, and a sticky flag for out-of-range selects.
//
// Ports
//   clk, rst          rising-edge clock; asynchronous active-high reset
//   src_in            packed sources; channel k = [k*DATA_WIDTH +: DATA_WIDTH]
//   sel               channel index
//   load, load_ready  capture request and its combinational acceptance
//   clear             synchronous clear to RESET_VALUE (highest priority)
//   acc_out           accumulator register
//   out_valid         acc_out holds a fresh, unconsumed value
//   out_ready         consumer takes acc_out this cycle
//   acc_zero, acc_neg registered flags of acc_out
//   sel_err, err_clr  sticky illegal-select flag and its clear
module acc_src_reg #(
    parameter int DATA_WIDTH = 11,
    parameter int NUM_SRC    = 3,
    parameter int SEL_WIDTH  = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_in,
    input  logic [SEL_WIDTH-1:0]          sel,
    input  logic                          load,
    input  logic                          clear,
    output logic                          load_ready,
    output logic [DATA_WIDTH-1:0]         acc_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          acc_zero,
    output logic                          acc_neg,
    output logic                          sel_err,
    input  logic                          err_clr
);

    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  valid_q, valid_d;
    logic                  zero_q, zero_d;
    logic                  neg_q, neg_d;
    logic                  err_q, err_d;

    logic [31:0]           sel_ext;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_illegal;
    logic                  take;
    logic                  load_ok;
    logic                  load_bad;

    // Zero-extend the select so the range test is a plain 32-bit compare.
    // When NUM_SRC is a power of two, this compare is constant-false.
    assign sel_ext     = 32'(sel);
    assign sel_illegal = (sel_ext >= 32'(NUM_SRC));

    // The mux uses an explicit decode. An out-of-range select therefore
    // yields zeros, never an out-of-bounds part-select.
    always_comb begin
        sel_data = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (sel_ext == k) begin
                sel_data = src_in[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign load_ready = !valid_q || out_ready;
    assign take       = load && load_ready && !clear;
    assign load_ok    = take && !sel_illegal;
    assign load_bad   = take && sel_illegal;

    always_comb begin
        acc_d   = acc_q;
        valid_d = valid_q;
        err_d   = err_q;

        if (clear) begin
            acc_d   = RESET_VALUE;
            valid_d = 1'b0;
        end else if (load_ok) begin
            acc_d   = sel_data;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        // Set wins over clear. A clear of the accumulator leaves this flag alone.
        if (load_bad) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end

        // The flags track the next accumulator value. They then always match acc_q.
        zero_d = (acc_d == '0);
        neg_d  = acc_d[DATA_WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= RESET_VALUE;
            valid_q <= 1'b0;
            zero_q  <= (RESET_VALUE == '0);
            neg_q   <= RESET_VALUE[DATA_WIDTH-1];
            err_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            valid_q <= valid_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
        end
    end

    assign acc_out   = acc_q;
    assign out_valid = valid_q;
    assign acc_zero  = zero_q;
    assign acc_neg   = neg_q;
    assign sel_err   = err_q;

endmodule

// File: tb/tb_acc_src_reg.sv
// tb_acc_src_reg
//   Scoreboard bench for acc_src_reg. It uses two instances: the default
//   configuration (11-bit, 3 sources) and a 16-bit, 4-source configuration.
//   Each load that should produce a fresh value pushes {zero, neg, acc}
//   into a queue. A monitor pops and compares the entry whenever the DUT
//   hands a value over (out_valid && out_ready). Register state that
//   involves no handshake is checked directly after the clock edge.
module tb_acc_src_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: defaults
    logic [32:0] a_src_in;
    logic [1:0]  a_sel;
    logic        a_load, a_clear, a_out_ready, a_err_clr;
    logic        a_load_ready, a_out_valid, a_acc_zero, a_acc_neg, a_sel_err;
    logic [10:0] a_acc_out;

    acc_src_reg u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .src_in     (a_src_in),
        .sel        (a_sel),
        .load       (a_load),
        .clear      (a_clear),
        .load_ready (a_load_ready),
        .acc_out    (a_acc_out),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .acc_zero   (a_acc_zero),
        .acc_neg    (a_acc_neg),
        .sel_err    (a_sel_err),
        .err_clr    (a_err_clr)
    );

    // Instance B: 16-bit data, 4 sources
    logic [63:0] b_src_in;
    logic [1:0]  b_sel;
    logic        b_load, b_clear, b_out_ready, b_err_clr;
    logic        b_load_ready, b_out_valid, b_acc_zero, b_acc_neg, b_sel_err;
    logic [15:0] b_acc_out;

    acc_src_reg #(
        .DATA_WIDTH (16),
        .NUM_SRC    (4)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .src_in     (b_src_in),
        .sel        (b_sel),
        .load       (b_load),
        .clear      (b_clear),
        .load_ready (b_load_ready),
        .acc_out    (b_acc_out),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .acc_zero   (b_acc_zero),
        .acc_neg    (b_acc_neg),
        .sel_err    (b_sel_err),
        .err_clr    (b_err_clr)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic z, input logic n, input logic [15:0] v);
        return {14'b0, z, n, v};
    endfunction

    // Monitor: a handshake at the coming edge consumes the value now presented.
    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_output", {21'b0, a_acc_out}, 32'hFFFF_FFFF);
            end else begin
                chk("a_scoreboard", pack(a_acc_zero, a_acc_neg, {5'b0, a_acc_out}), q_a.pop_front());
            end
        end
        if (!rst && b_out_valid && b_out_ready) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_output", {16'b0, b_acc_out}, 32'hFFFF_FFFF);
            end else begin
                chk("b_scoreboard", pack(b_acc_zero, b_acc_neg, b_acc_out), q_b.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        a_src_in = '0; a_sel = '0; a_load = 0; a_clear = 0; a_out_ready = 0; a_err_clr = 0;
        b_src_in = '0; b_sel = '0; b_load = 0; b_clear = 0; b_out_ready = 0; b_err_clr = 0;
        step(); step();
        rst = 1'b0;

        // Reset state
        chk("rst_acc",   {21'b0, a_acc_out}, 32'h0);
        chk("rst_valid", {31'b0, a_out_valid}, 32'h0);
        chk("rst_err",   {31'b0, a_sel_err}, 32'h0);
        chk("rst_zero",  {31'b0, a_acc_zero}, 32'h1);
        chk("rst_neg",   {31'b0, a_acc_neg}, 32'h0);
        chk("rst_ready", {31'b0, a_load_ready}, 32'h1);

        // Capture a value, then pulse reset while load is still requested
        a_src_in[32:22] = 11'h3A5; a_sel = 2'd2; a_load = 1;
        step();
        chk("pre_rst_acc", {21'b0, a_acc_out}, 32'h3A5);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_acc",   {21'b0, a_acc_out}, 32'h0);
        chk("async_rst_valid", {31'b0, a_out_valid}, 32'h0);
        chk("async_rst_zero",  {31'b0, a_acc_zero}, 32'h1);
        step();
        chk("hold_rst_acc", {21'b0, a_acc_out}, 32'h0);
        rst = 1'b0;

        // Basic load through ch2
        a_out_ready = 1;
        q_a.push_back(pack(1'b0, 1'b0, 16'h03A5));
        step();
        chk("load_acc",   {21'b0, a_acc_out}, 32'h3A5);
        chk("load_valid", {31'b0, a_out_valid}, 32'h1);
        a_load = 0;

        // Consume only
        step();
        chk("consume_valid", {31'b0, a_out_valid}, 32'h0);
        chk("consume_acc",   {21'b0, a_acc_out}, 32'h3A5);

        // Stall: ch0 = 0x400 while the consumer is not ready
        a_out_ready = 0; a_sel = 2'd0; a_src_in[10:0] = 11'h400; a_load = 1;
        q_a.push_back(pack(1'b0, 1'b1, 16'h0400));
        step();
        chk("stall_acc0",  {21'b0, a_acc_out}, 32'h400);
        chk("stall_neg",   {31'b0, a_acc_neg}, 32'h1);
        chk("stall_valid", {31'b0, a_out_valid}, 32'h1);
        a_sel = 2'd1; a_src_in[21:11] = 11'h001;
        #1;
        chk("stall_load_ready", {31'b0, a_load_ready}, 32'h0);
        step();
        chk("stall_hold_acc", {21'b0, a_acc_out}, 32'h400);
        a_out_ready = 1;
        q_a.push_back(pack(1'b0, 1'b0, 16'h0001));
        step();
        chk("stall_release_acc", {21'b0, a_acc_out}, 32'h001);
        chk("stall_release_valid", {31'b0, a_out_valid}, 32'h1);
        a_load = 0;
        step();

        // Illegal select
        a_sel = 2'd3; a_load = 1;
        step();
        chk("illegal_acc",   {21'b0, a_acc_out}, 32'h001);
        chk("illegal_err",   {31'b0, a_sel_err}, 32'h1);
        chk("illegal_valid", {31'b0, a_out_valid}, 32'h0);
        a_load = 0;
        step();
        chk("illegal_sticky", {31'b0, a_sel_err}, 32'h1);
        a_load = 1; a_err_clr = 1;
        step();
        chk("illegal_set_wins", {31'b0, a_sel_err}, 32'h1);
        a_load = 0;
        step();
        chk("err_clr", {31'b0, a_sel_err}, 32'h0);
        a_err_clr = 0;

        // Clear priority over load, including an illegal select
        a_sel = 2'd1; a_src_in[21:11] = 11'h7FF; a_load = 1;
        q_a.push_back(pack(1'b0, 1'b1, 16'h07FF));
        step();
        chk("pre_clear_acc", {21'b0, a_acc_out}, 32'h7FF);
        a_clear = 1; a_sel = 2'd3;
        step();
        chk("clear_acc",   {21'b0, a_acc_out}, 32'h0);
        chk("clear_zero",  {31'b0, a_acc_zero}, 32'h1);
        chk("clear_neg",   {31'b0, a_acc_neg}, 32'h0);
        chk("clear_valid", {31'b0, a_out_valid}, 32'h0);
        chk("clear_err",   {31'b0, a_sel_err}, 32'h0);
        a_clear = 0; a_load = 0;
        step();

        // Instance B: walk every channel back to back
        b_src_in = {16'hFFFF, 16'h1234, 16'h8001, 16'h0000};
        b_out_ready = 1; b_load = 1;
        for (int k = 0; k < 4; k++) begin
            logic [15:0] v;
            case (k)
                0: v = 16'h0000;
                1: v = 16'h8001;
                2: v = 16'h1234;
                default: v = 16'hFFFF;
            endcase
            b_sel = 2'(k);
            q_b.push_back(pack(v == 16'h0, v[15], v));
            step();
            chk("b_acc",  {16'b0, b_acc_out}, {16'b0, v});
            chk("b_zero", {31'b0, b_acc_zero}, {31'b0, v == 16'h0});
            chk("b_neg",  {31'b0, b_acc_neg}, {31'b0, v[15]});
            chk("b_err",  {31'b0, b_sel_err}, 32'h0);
        end
        b_load = 0;
        step();
        chk("b_drain_valid", {31'b0, b_out_valid}, 32'h0);

        chk("a_queue_empty", q_a.size(), 32'h0);
        chk("b_queue_empty", q_b.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
